// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB boundary, the register file and the hazard unit.
package mem_wb_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    // Architectural $zero: writes to it are discarded.
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : mem_wb_stage_pkg

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the M-stage instruction, drives the
// register-file write port and W forwarding value, turns StopM into W bubbles
// and counts retired instructions.
module mem_wb_stage #(
    parameter int DATA_W     = mem_wb_stage_pkg::DATA_W,
    parameter int REG_ADDR_W = mem_wb_stage_pkg::REG_ADDR_W,
    parameter int CNT_W      = mem_wb_stage_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  StopM,
    input  logic                  ValidM,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [DATA_W-1:0]     ALUOutM,
    input  logic [DATA_W-1:0]     MemOutM,
    output logic                  ValidW,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic [REG_ADDR_W-1:0] WriteRegW,
    output logic [DATA_W-1:0]     ALUOutW,
    output logic [DATA_W-1:0]     MemOutW,
    output logic [DATA_W-1:0]     ResultW,
    output logic [CNT_W-1:0]      RetireCountW
);

    import mem_wb_stage_pkg::*;

    logic                  valid_d,     valid_q;
    logic                  reg_write_d, reg_write_q;
    logic                  memto_reg_d, memto_reg_q;
    logic [REG_ADDR_W-1:0] write_reg_d, write_reg_q;
    logic [DATA_W-1:0]     alu_out_d,   alu_out_q;
    logic [DATA_W-1:0]     mem_out_d,   mem_out_q;
    logic [CNT_W-1:0]      retire_cnt_d, retire_cnt_q;

    // Next W state: capture M when it advances, otherwise insert a bubble and hold data.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        memto_reg_d = 1'b0;
        write_reg_d = write_reg_q;
        alu_out_d   = alu_out_q;
        mem_out_d   = mem_out_q;
        if (!StopM) begin
            valid_d     = ValidM;
            memto_reg_d = MemtoRegM;
            reg_write_d = RegWriteM & ValidM & (WriteRegM != REG_ADDR_W'(REG_ZERO));
            write_reg_d = WriteRegM;
            alu_out_d   = ALUOutM;
            mem_out_d   = MemOutM;
        end
    end

    // Retire counter: the instruction currently in W retires on this edge, stall or not.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (valid_q) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset; data flops are cleared too so ResultW reads 0.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
        if (reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            memto_reg_q  <= 1'b0;
            write_reg_q  <= '0;
            alu_out_q    <= '0;
            mem_out_q    <= '0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            memto_reg_q  <= memto_reg_d;
            write_reg_q  <= write_reg_d;
            alu_out_q    <= alu_out_d;
            mem_out_q    <= mem_out_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign ValidW       = valid_q;
    assign RegWriteW    = reg_write_q;
    assign MemtoRegW    = memto_reg_q;
    assign WriteRegW    = write_reg_q;
    assign ALUOutW      = alu_out_q;
    assign MemOutW      = mem_out_q;
    assign RetireCountW = retire_cnt_q;

    // Write-back select from registered state only; no M input reaches an output combinationally.
    assign ResultW = memto_reg_q ? mem_out_q : alu_out_q;

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a reference model pushes the expected W
// state when inputs are driven; it is popped and compared one edge later.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        StopM, ValidM, RegWriteM, MemtoRegM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM, MemOutM;

    logic        ValidW, RegWriteW, MemtoRegW;
    logic [4:0]  WriteRegW;
    logic [31:0] ALUOutW, MemOutW, ResultW, RetireCountW;

    // Narrow-counter build sharing the same stimulus, used for the wrap check.
    logic        ValidW_s, RegWriteW_s, MemtoRegW_s;
    logic [4:0]  WriteRegW_s;
    logic [31:0] ALUOutW_s, MemOutW_s, ResultW_s;
    logic [3:0]  RetireCountW_s;

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .StopM(StopM), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .ALUOutM(ALUOutM), .MemOutM(MemOutM),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .WriteRegW(WriteRegW), .ALUOutW(ALUOutW), .MemOutW(MemOutW),
        .ResultW(ResultW), .RetireCountW(RetireCountW)
    );

    mem_wb_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .StopM(StopM), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .ALUOutM(ALUOutM), .MemOutM(MemOutM),
        .ValidW(ValidW_s), .RegWriteW(RegWriteW_s), .MemtoRegW(MemtoRegW_s),
        .WriteRegW(WriteRegW_s), .ALUOutW(ALUOutW_s), .MemOutW(MemOutW_s),
        .ResultW(ResultW_s), .RetireCountW(RetireCountW_s)
    );

    typedef struct {
        logic        valid;
        logic        reg_write;
        logic        memto_reg;
        logic [4:0]  write_reg;
        logic [31:0] alu_out;
        logic [31:0] mem_out;
        logic [31:0] result;
        logic [31:0] count;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    exp_t m;   // model of the W-stage state

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive M inputs (at negedge), advance the model by one edge, push the expectation.
    task automatic drive(input logic r, input logic stop, input logic vm, input logic rwm,
                         input logic mtrm, input logic [4:0] wr, input logic [31:0] alu,
                         input logic [31:0] mem);
        exp_t n;
        reset = r; StopM = stop; ValidM = vm; RegWriteM = rwm; MemtoRegM = mtrm;
        WriteRegM = wr; ALUOutM = alu; MemOutM = mem;
        n = m;
        if (r) begin
            n.valid = 0; n.reg_write = 0; n.memto_reg = 0; n.write_reg = 0;
            n.alu_out = 0; n.mem_out = 0; n.count = 0;
        end else begin
            n.count = m.count + (m.valid ? 32'd1 : 32'd0);
            if (stop) begin
                n.valid = 0; n.reg_write = 0; n.memto_reg = 0;
            end else begin
                n.valid = vm; n.memto_reg = mtrm; n.write_reg = wr;
                n.alu_out = alu; n.mem_out = mem;
                n.reg_write = rwm && vm && (wr != 5'd0);
            end
        end
        n.result = n.memto_reg ? n.mem_out : n.alu_out;
        m = n;
        sb.push_back(n);
    endtask

    // One clock edge, then sample at the falling edge and pop the matching expectation.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            e = m;
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
            tick();
            checks++;
            if ({ValidW, RegWriteW, MemtoRegW, WriteRegW, ALUOutW, MemOutW, ResultW, RetireCountW} !== '0) begin
                errors++;
                $display("FAIL reset_idle%0d: got v=%0b rw=%0b mtr=%0b wr=%0d alu=%h mem=%h res=%h cnt=%0d, expected all 0",
                         i, ValidW, RegWriteW, MemtoRegW, WriteRegW, ALUOutW, MemOutW, ResultW, RetireCountW);
            end
        end
    endtask

    task automatic test_alu();
        drive(0, 0, 1, 1, 0, 5'd8, 32'h0000_0010, 32'h0);
        tick();
        checks++;
        if ({RegWriteW, WriteRegW, ResultW, ValidW} !== {1'b1, 5'd8, 32'h10, 1'b1} ||
            {RegWriteW, WriteRegW, ResultW, ValidW} !== {e.reg_write, e.write_reg, e.result, e.valid}) begin
            errors++;
            $display("FAIL alu_op: got rw=%0b wr=%0d res=%h v=%0b, expected rw=1 wr=8 res=00000010 v=1",
                     RegWriteW, WriteRegW, ResultW, ValidW);
        end
        drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        checks++;
        if (RetireCountW !== 32'd1 || RetireCountW !== e.count) begin
            errors++;
            $display("FAIL alu_retire: got %0d, expected 1", RetireCountW);
        end
    endtask

    task automatic test_load();
        drive(0, 0, 1, 1, 1, 5'd9, 32'h100, 32'hDEAD_BEEF);
        tick();
        checks++;
        if (ResultW !== 32'hDEAD_BEEF || MemOutW !== 32'hDEAD_BEEF || ALUOutW !== 32'h100 ||
            ResultW !== e.result || RegWriteW !== e.reg_write) begin
            errors++;
            $display("FAIL load: got res=%h mem=%h alu=%h rw=%0b, expected res=deadbeef mem=deadbeef alu=00000100 rw=1",
                     ResultW, MemOutW, ALUOutW, RegWriteW);
        end
    endtask

    task automatic test_stall();
        logic [31:0] c0;
        drive(0, 0, 1, 1, 1, 5'd9, 32'h100, 32'hDEAD_BEEF);
        tick();
        c0 = e.count;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 1, 0, 5'd10, 32'h200, 32'h1234_5678);
            tick();
            checks++;
            if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || MemOutW !== 32'hDEAD_BEEF ||
                WriteRegW !== 5'd9 || ALUOutW !== 32'h100) begin
                errors++;
                $display("FAIL stall%0d: got v=%0b rw=%0b mem=%h wr=%0d alu=%h, expected v=0 rw=0 mem=deadbeef wr=9 alu=00000100",
                         i, ValidW, RegWriteW, MemOutW, WriteRegW, ALUOutW);
            end
            checks++;
            if (RetireCountW !== c0 + 32'd1 || RetireCountW !== e.count) begin
                errors++;
                $display("FAIL stall_count%0d: got %0d, expected %0d", i, RetireCountW, c0 + 32'd1);
            end
        end
        drive(0, 0, 1, 1, 0, 5'd10, 32'h200, 32'h1234_5678);
        tick();
        checks++;
        if (ValidW !== 1'b1 || RegWriteW !== 1'b1 || WriteRegW !== 5'd10 || ResultW !== 32'h200 ||
            MemOutW !== 32'h1234_5678) begin
            errors++;
            $display("FAIL stall_release: got v=%0b rw=%0b wr=%0d res=%h mem=%h, expected v=1 rw=1 wr=10 res=00000200 mem=12345678",
                     ValidW, RegWriteW, WriteRegW, ResultW, MemOutW);
        end
    endtask

    task automatic test_zero_write();
        logic [31:0] c0;
        drive(0, 0, 1, 1, 0, 5'd0, 32'hABCD, 32'h0);
        tick();
        c0 = e.count;
        checks++;
        if (RegWriteW !== 1'b0 || ValidW !== 1'b1) begin
            errors++;
            $display("FAIL zero_write: got rw=%0b v=%0b, expected rw=0 v=1", RegWriteW, ValidW);
        end
        drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        checks++;
        if (RetireCountW !== c0 + 32'd1) begin
            errors++;
            $display("FAIL zero_write_count: got %0d, expected %0d", RetireCountW, c0 + 32'd1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive(0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom, $urandom);
            tick();
            checks++;
            if ({ValidW, RegWriteW, MemtoRegW, WriteRegW, ALUOutW, MemOutW, ResultW, RetireCountW} !==
                {e.valid, e.reg_write, e.memto_reg, e.write_reg, e.alu_out, e.mem_out, e.result, e.count}) begin
                errors++;
                $display("FAIL b2b%0d: got v=%0b rw=%0b mtr=%0b wr=%0d alu=%h mem=%h res=%h cnt=%0d, expected v=%0b rw=%0b mtr=%0b wr=%0d alu=%h mem=%h res=%h cnt=%0d",
                         i, ValidW, RegWriteW, MemtoRegW, WriteRegW, ALUOutW, MemOutW, ResultW, RetireCountW,
                         e.valid, e.reg_write, e.memto_reg, e.write_reg, e.alu_out, e.mem_out, e.result, e.count);
            end
            checks++;
            if ({ValidW_s, RegWriteW_s, MemtoRegW_s, WriteRegW_s, ALUOutW_s, MemOutW_s, ResultW_s, RetireCountW_s} !==
                {e.valid, e.reg_write, e.memto_reg, e.write_reg, e.alu_out, e.mem_out, e.result, e.count[3:0]}) begin
                errors++;
                $display("FAIL b2b_small%0d: got v=%0b rw=%0b res=%h cnt=%0d, expected v=%0b rw=%0b res=%h cnt=%0d",
                         i, ValidW_s, RegWriteW_s, ResultW_s, RetireCountW_s, e.valid, e.reg_write, e.result, e.count[3:0]);
            end
        end
    endtask

    task automatic test_reset_stall_wrap();
        drive(0, 0, 1, 1, 0, 5'd3, 32'h55, 32'h66);
        tick();
        drive(1, 1, 1, 1, 1, 5'd4, 32'h77, 32'h88);
        tick();
        checks++;
        if ({ValidW, RegWriteW, MemtoRegW, WriteRegW, ALUOutW, MemOutW, ResultW, RetireCountW, RetireCountW_s} !== '0) begin
            errors++;
            $display("FAIL reset_in_stall: got v=%0b rw=%0b wr=%0d res=%h cnt=%0d cnt4=%0d, expected all 0",
                     ValidW, RegWriteW, WriteRegW, ResultW, RetireCountW, RetireCountW_s);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 1, 0, 5'(i + 1), 32'(i), 32'h0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        checks++;
        if (RetireCountW_s !== 4'd0 || RetireCountW !== 32'd16 || RetireCountW !== e.count) begin
            errors++;
            $display("FAIL counter_wrap: got cnt4=%0d cnt32=%0d, expected cnt4=0 cnt32=16",
                     RetireCountW_s, RetireCountW);
        end
    endtask

    initial begin
        m = '{default: '0};
        test_reset();
        test_alu();
        test_load();
        test_stall();
        test_zero_write();
        test_back_to_back();
        test_reset_stall_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_wb_stage

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary of the 5-stage MIPS core, directly downstream of the memory I/O stage.
- Captures the M-stage ALU result, load data and control at the clock edge.
- Drives the register-file write port and the W-stage forwarding value.
- Turns a memory stall (StopM) into W-stage bubbles and keeps a retired-instruction counter.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register-file address width
CNT_W, 32, retire counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
StopM  input  1  memory stage stalled this cycle; M instruction not complete
ValidM  input  1  M stage holds a real instruction (0 = bubble)
RegWriteM  input  1  M instruction writes the register file
MemtoRegM  input  1  M instruction is a load
WriteRegM  input  REG_ADDR_W  destination register of M instruction
ALUOutM  input  DATA_W  ALU result / memory address from M
MemOutM  input  DATA_W  load data returned by memory in M
ValidW  output  1  W stage holds a retiring instruction
RegWriteW  output  1  register-file write enable
MemtoRegW  output  1  registered load flag
WriteRegW  output  REG_ADDR_W  register-file write address
ALUOutW  output  DATA_W  registered ALU result
MemOutW  output  DATA_W  registered load data (fed back to memory stage)
ResultW  output  DATA_W  write-back data, also the W forwarding source
RetireCountW  output  CNT_W  count of retired instructions

Behaviour:
- Reset: synchronous, active-high, highest priority. All registered outputs go to 0 on the edge where reset=1, including RetireCountW. ResultW is therefore 0.
- Normal edge (reset=0, StopM=0):
  - ValidW<=ValidM and MemtoRegW<=MemtoRegM.
  - WriteRegW<=WriteRegM, ALUOutW<=ALUOutM, MemOutW<=MemOutM.
  - RegWriteW<=RegWriteM & ValidM & (WriteRegM!=0). Writes to $zero are suppressed here.
- Stall edge (reset=0, StopM=1): a bubble is inserted.
  - ValidW<=0 and RegWriteW<=0. MemtoRegW<=0.
  - WriteRegW, ALUOutW and MemOutW hold their values. This keeps the MemOutW feedback stable.
  - The instruction held in M is captured on the first edge with StopM=0.
- Latency: exactly one cycle from M inputs to W outputs. No backpressure toward M beyond StopM, which is driven elsewhere.
- ResultW is combinational from registered state only:
  - MemOutW when MemtoRegW=1, else ALUOutW.
  - There is no combinational path from any M input to any output.
- Retire counter:
  - On every non-reset edge where ValidW=1 (the current W instruction retires), RetireCountW<=RetireCountW+1.
  - The count is based on the pre-edge ValidW, so it is independent of StopM.
  - Wraps modulo 2^CNT_W with no saturation or flag.
- Bubble input (ValidM=0, StopM=0): W loads a bubble. Data registers still capture the M values (don't-care). RegWriteW=0.
- Reset asserted during a stall: reset wins. All outputs are 0 on the next cycle.
- Consecutive stalls: bubbles continue and data registers keep holding.

Decomposition:
- Shared package: DATA_W, REG_ADDR_W and the REG_ZERO constant (5'd0), reused by the register file and hazard unit.
- No sub-module is needed. Everything is one register bank, one 2:1 result mux and one counter.

Test Plan:
1. Reset then 3 idle cycles -> every output 0, RetireCountW=0.
2. ALU op: ValidM=1, RegWriteM=1, MemtoRegM=0, WriteRegM=8, ALUOutM=0x00000010 -> next cycle RegWriteW=1, WriteRegW=8, ResultW=0x00000010, ValidW=1. One cycle later RetireCountW=1.
3. Load: MemtoRegM=1, WriteRegM=9, ALUOutM=0x100, MemOutM=0xDEADBEEF -> next cycle ResultW=0xDEADBEEF, MemOutW=0xDEADBEEF.
4. Stall: load as in 3 captured, then StopM=1 for 2 cycles with new M values -> ValidW=0 and RegWriteW=0 both cycles. MemOutW stays 0xDEADBEEF. RetireCountW increments once only. After StopM=0 the new M instruction appears.
5. $zero write: RegWriteM=1, WriteRegM=0, ValidM=1 -> RegWriteW=0, ValidW=1, counter still increments.
6. Reset with StopM=1 mid-stream, and counter preloaded by 2^32 retirements (or CNT_W=4 build, 16 retirements) -> outputs 0 after reset. Counter wraps to 0 with no error.
